// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared types and constants for the MLP output layer
package mlp_pkg;

    localparam int N_CLASS   = 10;
    localparam int ACC_W_DEF = 27;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUN      = 3'd1,
        S_BIAS_RD  = 3'd2,
        S_BIAS_ADD = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    localparam longint SAT_MAX_DEF = sat_max(ACC_W_DEF);
    localparam longint SAT_MIN_DEF = sat_min(ACC_W_DEF);

endpackage

// File: rtl/mlp_output_layer_mac_sat_lane.sv
// rtl/mlp_output_layer_mac_sat_lane.sv - one class lane: saturating multiply-accumulate and bias add
module mac_sat_lane
    import mlp_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int W_W   = 8,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    mac_en,
    input  logic                    bias_en,
    input  logic signed [IN_W-1:0]  feat,
    input  logic signed [W_W-1:0]   weight,
    output logic signed [ACC_W-1:0] acc
);

    localparam int P_W = IN_W + W_W;
    localparam logic signed [ACC_W:0] SAT_HI = (ACC_W + 1)'(sat_max(ACC_W));
    localparam logic signed [ACC_W:0] SAT_LO = (ACC_W + 1)'(sat_min(ACC_W));

    logic signed [P_W-1:0] prod;
    logic signed [ACC_W:0] term;
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] sat;

    // One guard bit above the accumulator is enough to detect any overflow
    // of a single term, so clamping applies per step and never sticks.
    always_comb begin
        prod = feat * weight;
        term = mac_en ? (ACC_W + 1)'(prod) : (ACC_W + 1)'(weight);
        sum  = (ACC_W + 1)'(acc) + term;
        if (sum > SAT_HI)
            sat = SAT_HI;
        else if (sum < SAT_LO)
            sat = SAT_LO;
        else
            sat = sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (mac_en || bias_en)
            acc <= sat[ACC_W-1:0];
    end

endmodule

// File: rtl/mlp_output_layer.sv
// rtl/mlp_output_layer.sv - final MLP layer: streamed features x ROM weight rows plus bias, ten class scores
module mlp_output_layer
    import mlp_pkg::*;
#(
    parameter int N_IN   = 64,
    parameter int IN_W   = 8,
    parameter int W_W    = 8,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int ADDR_W = $clog2(N_IN + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [IN_W-1:0]     in_data,
    output logic [ADDR_W-1:0]          w_addr,
    output logic                       w_rd_en,
    input  logic [N_CLASS*W_W-1:0]     w_data,
    output logic signed [ACC_W-1:0]    data_0,
    output logic signed [ACC_W-1:0]    data_1,
    output logic signed [ACC_W-1:0]    data_2,
    output logic signed [ACC_W-1:0]    data_3,
    output logic signed [ACC_W-1:0]    data_4,
    output logic signed [ACC_W-1:0]    data_5,
    output logic signed [ACC_W-1:0]    data_6,
    output logic signed [ACC_W-1:0]    data_7,
    output logic signed [ACC_W-1:0]    data_8,
    output logic signed [ACC_W-1:0]    data_9,
    output logic                       mlp_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IN - 1);
    localparam logic [ADDR_W-1:0] BIAS_ADDR = ADDR_W'(N_IN);

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_W-1:0]       count;
    logic signed [IN_W-1:0]  feat_q;
    logic                    mac_pend;
    logic                    clr;
    logic                    accept;
    logic                    bias_en;
    logic signed [ACC_W-1:0] acc [N_CLASS];

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        w_rd_en   = 1'b0;
        w_addr    = '0;
        clr       = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    clr       = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    w_rd_en = 1'b1;
                    w_addr  = count;
                    if (count == LAST_ADDR)
                        state_nxt = S_BIAS_RD;
                end
            end
            S_BIAS_RD: begin
                w_rd_en   = 1'b1;
                w_addr    = BIAS_ADDR;
                state_nxt = S_BIAS_ADD;
            end
            S_BIAS_ADD: state_nxt = S_DONE;
            S_DONE: begin
                if (start) begin
                    clr       = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The feature is held one cycle so it meets its ROM row, which returns
    // one cycle after the read; mac_pend marks that pairing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            count    <= '0;
            feat_q   <= '0;
            mac_pend <= 1'b0;
            mlp_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            mac_pend <= accept;
            mlp_done <= (state == S_DONE) && !start;
            if (clr)
                count <= '0;
            else if (accept)
                count <= count + 1'b1;
            if (accept)
                feat_q <= in_data;
        end
    end

    assign bias_en = (state == S_BIAS_ADD);

    for (genvar j = 0; j < N_CLASS; j++) begin : g_lane
        mac_sat_lane #(
            .IN_W  (IN_W),
            .W_W   (W_W),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (clr),
            .mac_en  (mac_pend),
            .bias_en (bias_en),
            .feat    (feat_q),
            .weight  (w_data[j*W_W +: W_W]),
            .acc     (acc[j])
        );
    end

    assign data_0 = acc[0];
    assign data_1 = acc[1];
    assign data_2 = acc[2];
    assign data_3 = acc[3];
    assign data_4 = acc[4];
    assign data_5 = acc[5];
    assign data_6 = acc[6];
    assign data_7 = acc[7];
    assign data_8 = acc[8];
    assign data_9 = acc[9];

endmodule

// File: tb/tb_mlp_output_layer.sv
// tb/tb_mlp_output_layer.sv - directed vector bench for mlp_output_layer (27-bit and 16-bit instances)
module tb_mlp_output_layer;

    logic clk = 1'b0;
    logic rst_n, start, in_valid;
    logic signed [7:0] in_data;
    logic in_ready_a, in_ready_b, w_rd_en_a, w_rd_en_b, done_a, done_b;
    logic [2:0] w_addr_a, w_addr_b;
    logic [79:0] w_data_a, w_data_b;
    logic signed [26:0] da [10];
    logic signed [15:0] db [10];
    logic [79:0] rom [0:4];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mlp_output_layer #(.N_IN(4), .ACC_W(27)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_a), .in_data(in_data), .w_addr(w_addr_a),
        .w_rd_en(w_rd_en_a), .w_data(w_data_a),
        .data_0(da[0]), .data_1(da[1]), .data_2(da[2]), .data_3(da[3]), .data_4(da[4]),
        .data_5(da[5]), .data_6(da[6]), .data_7(da[7]), .data_8(da[8]), .data_9(da[9]),
        .mlp_done(done_a)
    );

    mlp_output_layer #(.N_IN(4), .ACC_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_b), .in_data(in_data), .w_addr(w_addr_b),
        .w_rd_en(w_rd_en_b), .w_data(w_data_b),
        .data_0(db[0]), .data_1(db[1]), .data_2(db[2]), .data_3(db[3]), .data_4(db[4]),
        .data_5(db[5]), .data_6(db[6]), .data_7(db[7]), .data_8(db[8]), .data_9(db[9]),
        .mlp_done(done_b)
    );

    always @(posedge clk) begin
        if (w_rd_en_a) w_data_a <= rom[w_addr_a];
        if (w_rd_en_b) w_data_b <= rom[w_addr_b];
    end

    typedef struct {
        int         f [4];
        logic [7:0] vmask;
        int         rom_sel;
        bit         poke;
        int         a_l0, a_base, a_step;
        int         b_l0, b_base, b_step;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    function automatic longint expv(input int l0, input int base, input int step, input int j);
        return (j == 0) ? longint'(l0) : longint'(base + step * j);
    endfunction

    // sel 0: lane j weight j, bias 0; sel 1: lane0 7,-4,9,-1 bias -10, others weight 1 bias j;
    // sel 2: every weight 127, bias 0
    task automatic load_rom(input int sel);
        int w0 [4];
        int val;
        w0 = '{7, -4, 9, -1};
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < 10; j++) begin
                case (sel)
                    0:       val = (r < 4) ? j : 0;
                    1:       val = (j == 0) ? ((r < 4) ? w0[r] : -10) : ((r < 4) ? 1 : j);
                    default: val = (r < 4) ? 127 : 0;
                endcase
                rom[r][j*8 +: 8] = 8'(val);
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int nacc, k, lat, nadr;
        logic [14:0] alog;
        load_rom(v.rom_sel);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nacc = 0; k = 0; nadr = 0; alog = '0;
        while (nacc < 4 && k < 40) begin
            in_valid = (k < 8) ? v.vmask[k] : 1'b1;
            in_data  = 8'(v.f[nacc]);
            start    = v.poke && (k == 1);
            #1;
            if (w_rd_en_a) begin
                alog = {alog[11:0], w_addr_a};
                nadr++;
            end
            if (in_valid && in_ready_a) nacc++;
            @(negedge clk);
            k++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk($sformatf("v%0d accepts", idx), nacc, 4);
        chk($sformatf("v%0d in_ready_drop", idx), in_ready_a, 0);
        lat = 0;
        while (!done_a && lat < 20) begin
            if (w_rd_en_a) begin
                alog = {alog[11:0], w_addr_a};
                nadr++;
            end
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v%0d done_latency", idx), lat, 3);
        chk($sformatf("v%0d rd_count", idx), nadr, 5);
        chk($sformatf("v%0d addr_seq", idx), alog, 15'b000_001_010_011_100);
        chk($sformatf("v%0d done_b", idx), done_b, 1);
        for (int j = 0; j < 10; j++) begin
            chk($sformatf("v%0d a.data_%0d", idx, j), da[j], expv(v.a_l0, v.a_base, v.a_step, j));
            chk($sformatf("v%0d b.data_%0d", idx, j), db[j], expv(v.b_l0, v.b_base, v.b_step, j));
        end
    endtask

    initial begin
        int any_nz;
        vecs[0] = '{'{1, 1, 1, 1},         8'hFF, 0, 1'b0, 0, 0, 4, 0, 0, 4};
        vecs[1] = '{'{1, 1, 1, 1},         8'h59, 0, 1'b0, 0, 0, 4, 0, 0, 4};
        vecs[2] = '{'{-3, 2, 0, 5},        8'hFF, 1, 1'b1, -44, 4, 1, -44, 4, 1};
        vecs[3] = '{'{10, -20, 30, -40},   8'h1B, 0, 1'b0, 0, 0, -20, 0, 0, -20};
        vecs[4] = '{'{127, 127, 127, 127}, 8'hFF, 2, 1'b0, 64516, 64516, 0, 32767, 32767, 0};
        vecs[5] = '{'{-128, -128, -128, -128}, 8'hFF, 2, 1'b0, -65024, -65024, 0, -32768, -32768, 0};
        vecs[6] = '{'{127, 127, 127, -128}, 8'hFF, 2, 1'b0, 32131, 32131, 0, 16511, 16511, 0};

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        load_rom(0);
        repeat (3) @(negedge clk);
        chk("rst in_ready", in_ready_a, 0);
        chk("rst w_rd_en", w_rd_en_a, 0);
        chk("rst w_addr", w_addr_a, 0);
        chk("rst mlp_done", done_a, 0);
        chk("rst data_9", da[9], 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("hold%0d done", c), done_a, 1);
            chk($sformatf("hold%0d a.data_5", c), da[5], 32131);
            chk($sformatf("hold%0d b.data_5", c), db[5], 16511);
        end

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart done_drop", done_a, 0);
        chk("restart data_5 clr", da[5], 0);
        chk("restart in_ready", in_ready_a, 1);
        run_vec(vecs[3], 7);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'sd5;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        any_nz = 0;
        for (int j = 0; j < 10; j++) if (da[j] != 0 || db[j] != 0) any_nz++;
        chk("midrst data nonzero lanes", any_nz, 0);
        chk("midrst in_ready", in_ready_a, 0);
        chk("midrst w_rd_en", w_rd_en_a, 0);
        chk("midrst mlp_done", done_a, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(vecs[0], 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
